// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface pc_fetch_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);
  logic               req;
  logic [PC_W-1:0]    addr;
  logic               ack;
  logic [INSTR_W-1:0] data;

  modport master (output req, addr, input  ack, data);
  modport slave  (input  req, addr, output ack, data);
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches one word at a time over the
// imem bus and presents it in ir until decode consumes it or a branch flushes it.
module pc_fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  pc_fetch_unit_if.master    imem,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [PC_W-1:0]    pc_d, ir_pc_d;
  logic [INSTR_W-1:0] ir_d;
  logic               ir_valid_d;

  // NOTE: sequential state uses <= so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      ir       <= ir_d;
      ir_pc    <= ir_pc_d;
      ir_valid <= ir_valid_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first, so no path leaves a latch behind.
    state_d    = state;
    pc_d       = pc;
    ir_d       = ir;
    ir_pc_d    = ir_pc;
    ir_valid_d = ir_valid;

    unique case (state)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem.ack) begin
          ir_d       = imem.data;
          ir_pc_d    = pc;
          ir_valid_d = 1'b1;
          pc_d       = pc + 1'b1;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (!stall) begin
          ir_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect overrides whatever the state decided, including a same-cycle ack.
    if (br_taken && state != S_IDLE) begin
      state_d    = S_REQ;
      pc_d       = br_target;
      ir_d       = ir;
      ir_pc_d    = ir_pc;
      ir_valid_d = 1'b0;
    end
  end

  assign imem.req  = (state == S_REQ);
  assign imem.addr = pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed walk through the fetch scenarios, then random traffic, all scored
// against a cycle-level behavioural model of the fetch rules.
module tb_pc_fetch_unit;
  localparam int        PC_W     = 8;
  localparam int        INSTR_W  = 16;
  localparam logic [7:0] RESET_PC = 8'h00;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               stall;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0]    ir_pc;
  logic               ir_valid;

  pc_fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) imem ();

  pc_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .imem      (imem),
    .pc        (pc),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: "started" means the first post-reset edge has passed;
  // a fetch is outstanding whenever started and no instruction is held.
  bit               m_started;
  bit               m_valid;
  logic [PC_W-1:0]  m_pc;
  logic [PC_W-1:0]  m_ir_pc;
  logic [INSTR_W-1:0] m_ir;

  function automatic void model_reset();
    m_started = 1'b0;
    m_valid   = 1'b0;
    m_pc      = RESET_PC;
    m_ir_pc   = '0;
    m_ir      = '0;
  endfunction

  function automatic void model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!m_started) begin
      m_started = 1'b1;
    end else if (br_taken) begin
      m_pc    = br_target;
      m_valid = 1'b0;
    end else if (!m_valid) begin
      if (imem.ack) begin
        m_ir    = imem.data;
        m_ir_pc = m_pc;
        m_valid = 1'b1;
        m_pc    = PC_W'((int'(m_pc) + 1) % (1 << PC_W));
      end
    end else if (!stall) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},       32'(pc),        32'(m_pc));
    chk({tag, ".ir"},       32'(ir),        32'(m_ir));
    chk({tag, ".ir_pc"},    32'(ir_pc),     32'(m_ir_pc));
    chk({tag, ".ir_valid"}, 32'(ir_valid),  32'(m_valid));
    chk({tag, ".req"},      32'(imem.req),  32'(m_started && !m_valid));
    chk({tag, ".addr"},     32'(imem.addr), 32'(m_pc));
  endtask

  task automatic cycle(input bit s, input bit b, input logic [PC_W-1:0] t,
                       input bit a, input logic [INSTR_W-1:0] d, input string tag);
    stall     = s;
    br_taken  = b;
    br_target = t;
    imem.ack  = a;
    imem.data = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    stall     = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    imem.ack  = 1'b0;
    imem.data = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check_all("reset");
    chk("reset.req", 32'(imem.req), 32'd0);
    rst_n = 1'b1;
    cycle(0, 0, 8'h00, 0, 16'h0000, "idle_exit");
    chk("first_req", 32'(imem.req), 32'd1);

    // Zero-wait memory, data = addr + 0x100
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 8'h00, 1, 16'(k + 16'h100), "zw_ack");
      chk("zw.ir", 32'(ir), 32'(k + 16'h100));
      chk("zw.valid", 32'(ir_valid), 32'd1);
      cycle(0, 0, 8'h00, 0, 16'h0000, "zw_take");
      chk("zw.addr", 32'(imem.addr), 32'(k + 1));
      chk("zw.novalid", 32'(ir_valid), 32'd0);
    end

    // Three wait cycles at address 5
    for (int w = 0; w < 3; w++) begin
      cycle(0, 0, 8'h00, 0, 16'hFFFF, "wait");
      chk("wait.addr", 32'(imem.addr), 32'd5);
    end
    cycle(0, 0, 8'h00, 1, 16'h0505, "wait_ack");
    chk("wait.ir_pc", 32'(ir_pc), 32'd5);
    cycle(0, 0, 8'h00, 0, 16'h0000, "wait_take");

    // Stall holds ir=0xBEEF from address 2
    cycle(0, 1, 8'h02, 0, 16'h0000, "br2");
    cycle(1, 0, 8'h00, 1, 16'hBEEF, "beef_ack");
    for (int s = 0; s < 4; s++) begin
      cycle(1, 0, 8'h00, 1, 16'($urandom), "stall");
      chk("stall.ir", 32'(ir), 32'hBEEF);
      chk("stall.pc", 32'(pc), 32'd3);
    end
    cycle(0, 0, 8'h00, 0, 16'h0000, "unstall");
    chk("unstall.addr", 32'(imem.addr), 32'd3);

    // Branch beats a same-cycle ack; branch beats stall
    cycle(0, 1, 8'h07, 0, 16'h0000, "br7");
    cycle(0, 1, 8'h40, 1, 16'hDEAD, "br_vs_ack");
    chk("br_vs_ack.ir", 32'(ir), 32'hBEEF);
    chk("br_vs_ack.addr", 32'(imem.addr), 32'h40);
    cycle(0, 0, 8'h00, 1, 16'h4040, "ack40");
    cycle(1, 1, 8'h80, 0, 16'h0000, "br_vs_stall");
    chk("br_vs_stall.valid", 32'(ir_valid), 32'd0);
    chk("br_vs_stall.addr", 32'(imem.addr), 32'h80);

    // PC wrap at 0xFF
    cycle(0, 1, 8'hFF, 0, 16'h0000, "brFF");
    cycle(0, 0, 8'h00, 1, 16'h01FF, "wrap_ack");
    chk("wrap.ir_pc", 32'(ir_pc), 32'hFF);
    chk("wrap.pc", 32'(pc), 32'h00);
    cycle(0, 0, 8'h00, 0, 16'h0000, "wrap_take");
    chk("wrap.addr", 32'(imem.addr), 32'h00);

    // Asynchronous reset in the middle of a request at address 9
    cycle(0, 1, 8'h09, 0, 16'h0000, "br9");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst");
    chk("mid_rst.req", 32'(imem.req), 32'd0);
    cycle(0, 0, 8'h00, 1, 16'h0999, "in_rst");
    rst_n = 1'b1;
    cycle(0, 1, 8'h33, 1, 16'h0777, "idle_ignore");
    chk("refetch.addr", 32'(imem.addr), 32'(RESET_PC));
    cycle(0, 0, 8'h00, 1, 16'h0100, "refetch_ack");
    chk("refetch.ir_pc", 32'(ir_pc), 32'(RESET_PC));

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rnd_rst");
        rst_n = 1'b1;
      end
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 8'($urandom),
            $urandom_range(0, 1) == 1, 16'($urandom), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
